spi_reg_ctrl: RTL and testbench

//  Byte-level command controller sequencing the spi_slave peripheral. Decodes SPI frames
//  (command byte, then data bytes) into writes/reads of a local register bank, preloads the
//  spi_slave transmit byte (din) for read responses, and exposes the bank to fabric logic
//  (LEDs, neuron config). Sits between spi_slave {done, dout, din} and the user design.

---
 rtl/spi_reg_pkg.sv | 12 +
 rtl/spi_reg_ctrl_if.sv | 10 +
 rtl/spi_reg_bank.sv | 39 +++
 rtl/spi_reg_ctrl.sv | 126 ++++++++++++
 tb/tb_spi_reg_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register controller.
package spi_reg_pkg;
    typedef enum logic [1:0] {IDLE, CMD, DATA} spi_reg_state_t;

    localparam int         CMD_RW_BIT   = 7;
    localparam int         ADDR_W       = 7;
    localparam logic [7:0] ERR_CLR_CODE = 8'hFF;

    function automatic logic addr_in_bank(input logic [ADDR_W-1:0] a, input int num_regs);
        return int'(a) < num_regs;
    endfunction
endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between spi_slave and the register controller.
interface spi_reg_ctrl_if;
    logic       ss;
    logic       rx_done;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;

    modport master (output ss, rx_done, rx_byte, input tx_byte);
    modport slave  (input ss, rx_done, rx_byte, output tx_byte);
endinterface

// File: rtl/spi_reg_bank.sv
// Register array with a single write port and a combinational mem(a) read mux.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int               NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = 7'h7F,
    parameter logic [7:0]       RST_VAL     = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [7:0]            wdata,
    input  logic [ADDR_W-1:0]     raddr,
    input  logic [7:0]            status_in,
    output logic [7:0]            rdata,
    output logic [NUM_REGS*8-1:0] regs_q
);
    logic [NUM_REGS-1:0][7:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= {NUM_REGS{RST_VAL}};
        end else if (we) begin
            for (int k = 0; k < NUM_REGS; k++)
                if (waddr == ADDR_W'(k)) mem[k] <= wdata;
        end
    end

    // Bank addresses take priority over the status address; anything else reads 0.
    always_comb begin
        rdata = 8'h00;
        if (raddr == STATUS_ADDR) rdata = status_in;
        for (int k = 0; k < NUM_REGS; k++)
            if (raddr == ADDR_W'(k)) rdata = mem[k];
    end

    assign regs_q = mem;
endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI frame decoder driving a local register bank; optional reg0[7] write lock
// enabled by defining SPI_REG_WLOCK_EN.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int               NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = 7'h7F,
    parameter logic [7:0]       RST_VAL     = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_reg_ctrl_if.slave         spi,
    input  logic [7:0]            status_in,
    output logic [NUM_REGS*8-1:0] regs_q,
    output logic                  wr_pulse,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic                  frame_err
);
    spi_reg_state_t    state;
    logic              ss_meta, ss_s;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q, next_addr;
    logic              tx_load;
    logic [7:0]        tx_q;
    logic [7:0]        rd_data;
    logic              in_bank, is_status, locked, wr_ev, bank_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_meta <= 1'b1;
            ss_s    <= 1'b1;
        end else begin
            ss_meta <= spi.ss;
            ss_s    <= ss_meta;
        end
    end

    assign in_bank   = addr_in_bank(addr_q, NUM_REGS);
    assign is_status = (addr_q == STATUS_ADDR) && !in_bank;

`ifdef SPI_REG_WLOCK_EN
    assign locked = regs_q[7] && (addr_q != '0) && in_bank;
`else
    assign locked = 1'b0;
`endif

    assign wr_ev   = (state == DATA) && !ss_s && spi.rx_done && !rw_q;
    assign bank_we = wr_ev && in_bank && !locked;

    // Wrap at the top of the bank; the status/unmapped addresses hold.
    always_comb begin
        if (int'(addr_q) == NUM_REGS - 1) next_addr = '0;
        else if (in_bank)                 next_addr = addr_q + ADDR_W'(1);
        else                              next_addr = addr_q;
    end

    spi_reg_bank #(
        .NUM_REGS    (NUM_REGS),
        .STATUS_ADDR (STATUS_ADDR),
        .RST_VAL     (RST_VAL)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .we        (bank_we),
        .waddr     (addr_q),
        .wdata     (spi.rx_byte),
        .raddr     (addr_q),
        .status_in (status_in),
        .rdata     (rd_data),
        .regs_q    (regs_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            tx_load   <= 1'b0;
            tx_q      <= 8'h00;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            tx_load  <= 1'b0;
            // Read data lands one cycle after the address is settled.
            if (tx_load) begin
                tx_q <= rd_data;
                if (!in_bank && !is_status) frame_err <= 1'b1;
            end
            if (ss_s) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state <= CMD;
                        tx_q  <= 8'h00;
                    end
                    CMD: if (spi.rx_done) begin
                        rw_q   <= spi.rx_byte[CMD_RW_BIT];
                        addr_q <= spi.rx_byte[ADDR_W-1:0];
                        state  <= DATA;
                        if (spi.rx_byte[CMD_RW_BIT]) tx_load <= 1'b1;
                        else                         tx_q    <= 8'h00;
                    end
                    DATA: if (spi.rx_done) begin
                        addr_q <= next_addr;
                        if (rw_q) begin
                            tx_load <= 1'b1;
                        end else if (bank_we) begin
                            wr_pulse <= 1'b1;
                            wr_addr  <= addr_q;
                        end else if (is_status) begin
                            if (spi.rx_byte == ERR_CLR_CODE) frame_err <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign spi.tx_byte = tx_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: byte-level SPI frames against a frame-level model.
module tb_spi_reg_ctrl;
    import spi_reg_pkg::*;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] status_in;
    logic [N*8-1:0] regs_q;
    logic wr_pulse;
    logic [6:0] wr_addr;
    logic frame_err;

    always #5 clk = ~clk;

    spi_reg_ctrl_if sif ();

    spi_reg_ctrl #(.NUM_REGS(N), .STATUS_ADDR(7'h7F), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .spi(sif.slave), .status_in(status_in),
        .regs_q(regs_q), .wr_pulse(wr_pulse), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    int checks = 0, failures = 0;
    logic [7:0] mregs [N];
    bit merr;
    int exp_wq[$], got_wq[$];
    logic [7:0] fb[16], miso[16], exp_miso[16];

    always @(negedge clk) if (wr_pulse === 1'b1) got_wq.push_back(int'(wr_addr));

    function automatic logic [7:0] mread(input int a);
        if (a < N) return mregs[a];
        if (a == 127) return status_in;
        return 8'h00;
    endfunction

    function automatic int minc(input int a);
        if (a == N - 1) return 0;
        if (a < N) return a + 1;
        return a;
    endfunction

    function automatic bit mlocked(input int a);
`ifdef SPI_REG_WLOCK_EN
        return (a != 0) && (a < N) && mregs[0][7];
`else
        return (a < 0);
`endif
    endfunction

    function automatic logic [N*8-1:0] mflat();
        logic [N*8-1:0] v;
        for (int k = 0; k < N; k++) v[k*8 +: 8] = mregs[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) mregs[k] = 8'h00;
        merr = 0;
        exp_wq.delete();
    endtask

    // Applies one completed frame of n bytes (fb[0..n-1]) to the model.
    task automatic model_frame(input int n);
        int a;
        bit rw;
        logic [7:0] c;
        c = fb[0];
        rw = c[7];
        a = int'(c[6:0]);
        exp_miso[0] = 8'h00;
        for (int i = 1; i < n; i++) begin
            if (rw) begin
                exp_miso[i] = mread(a);
                if (a >= N && a != 127) merr = 1;
            end else begin
                exp_miso[i] = 8'h00;
                if (a < N) begin
                    if (mlocked(a)) merr = 1;
                    else begin mregs[a] = fb[i]; exp_wq.push_back(a); end
                end else if (a == 127) begin
                    if (fb[i] == 8'hFF) merr = 0;
                end else merr = 1;
            end
            a = minc(a);
        end
        if (rw && a >= N && a != 127) merr = 1;
    endtask

    task automatic run_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            miso[i] = sif.tx_byte;
            sif.rx_byte = fb[i];
            sif.rx_done = 1'b1;
            @(negedge clk);
            sif.rx_done = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic run_frame(input int n);
        sif.ss = 1'b0;
        repeat (4) @(negedge clk);
        run_bytes(n);
        sif.ss = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_frame(input int n);
        model_frame(n);
        run_frame(n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        got_wq.delete();
        checks++; if (regs_q !== '0) begin failures++; $display("FAIL reset_regs got %h exp 0", regs_q); end
        checks++; if (sif.tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx got %h exp 00", sif.tx_byte); end
        checks++; if (wr_pulse !== 1'b0) begin failures++; $display("FAIL reset_wr_pulse got %b exp 0", wr_pulse); end
        checks++; if (wr_addr !== 7'd0) begin failures++; $display("FAIL reset_wr_addr got %h exp 0", wr_addr); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    endtask

    task automatic test_write();
        got_wq.delete(); exp_wq.delete();
        fb[0] = 8'h02; fb[1] = 8'hA5;
        do_frame(2);
        checks++; if (regs_q[23:16] !== 8'hA5) begin failures++; $display("FAIL write_reg2 got %h exp a5", regs_q[23:16]); end
        checks++; if (regs_q !== mflat()) begin failures++; $display("FAIL write_bank got %h exp %h", regs_q, mflat()); end
        checks++; if (got_wq.size() != 1) begin failures++; $display("FAIL write_pulses got %0d exp 1", got_wq.size()); end
        else begin
            checks++; if (got_wq[0] != 2) begin failures++; $display("FAIL write_addr got %0d exp 2", got_wq[0]); end
        end
    endtask

    task automatic test_read();
        fb[0] = 8'h02; fb[1] = 8'hA5; fb[2] = 8'h3C;
        do_frame(3);
        fb[0] = 8'h82; fb[1] = 8'h5E; fb[2] = 8'hC3;
        do_frame(3);
        checks++; if (miso[0] !== 8'h00) begin failures++; $display("FAIL read_b0 got %h exp 00", miso[0]); end
        checks++; if (miso[1] !== 8'hA5) begin failures++; $display("FAIL read_b1 got %h exp a5", miso[1]); end
        checks++; if (miso[2] !== 8'h3C) begin failures++; $display("FAIL read_b2 got %h exp 3c", miso[2]); end
    endtask

    task automatic test_wrap();
        fb[0] = 8'h06; fb[1] = 8'h11; fb[2] = 8'h22; fb[3] = 8'h33;
        do_frame(4);
        checks++; if (regs_q[55:48] !== 8'h11) begin failures++; $display("FAIL wrap_reg6 got %h exp 11", regs_q[55:48]); end
        checks++; if (regs_q[63:56] !== 8'h22) begin failures++; $display("FAIL wrap_reg7 got %h exp 22", regs_q[63:56]); end
        checks++; if (regs_q[7:0] !== 8'h33) begin failures++; $display("FAIL wrap_reg0 got %h exp 33", regs_q[7:0]); end
    endtask

    task automatic test_status();
        status_in = 8'h5A;
        got_wq.delete(); exp_wq.delete();
        fb[0] = 8'hFF; fb[1] = 8'h00;
        do_frame(2);
        checks++; if (miso[1] !== 8'h5A) begin failures++; $display("FAIL status_read got %h exp 5a", miso[1]); end
        fb[0] = 8'h95; fb[1] = 8'h00;
        do_frame(2);
        checks++; if (miso[1] !== 8'h00) begin failures++; $display("FAIL unmapped_read got %h exp 00", miso[1]); end
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL unmapped_err got %b exp 1", frame_err); end
        fb[0] = 8'h7F; fb[1] = 8'h12;
        do_frame(2);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL status_noclr got %b exp 1", frame_err); end
        fb[0] = 8'h7F; fb[1] = 8'hFF;
        do_frame(2);
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL status_clr got %b exp 0", frame_err); end
        checks++; if (got_wq.size() != 0) begin failures++; $display("FAIL status_pulses got %0d exp 0", got_wq.size()); end
    endtask

    task automatic test_abort();
        logic [7:0] r4;
        got_wq.delete(); exp_wq.delete();
        fb[0] = 8'h01;
        do_frame(1);
        fb[0] = 8'h01; fb[1] = 8'h77;
        do_frame(2);
        checks++; if (regs_q[15:8] !== 8'h77) begin failures++; $display("FAIL abort_reg1 got %h exp 77", regs_q[15:8]); end
        // Byte arriving once the synchronized ss has risen must be dropped.
        r4 = mregs[4];
        got_wq.delete();
        sif.ss = 1'b0;
        repeat (4) @(negedge clk);
        fb[0] = 8'h04;
        run_bytes(1);
        sif.ss = 1'b1;
        repeat (2) @(negedge clk);
        sif.rx_byte = 8'h99; sif.rx_done = 1'b1;
        @(negedge clk);
        sif.rx_done = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (regs_q[39:32] !== r4) begin failures++; $display("FAIL drop_reg4 got %h exp %h", regs_q[39:32], r4); end
        checks++; if (got_wq.size() != 0) begin failures++; $display("FAIL drop_pulses got %0d exp 0", got_wq.size()); end
    endtask

    task automatic test_reset_midframe();
        sif.ss = 1'b0;
        repeat (4) @(negedge clk);
        fb[0] = 8'h03;
        run_bytes(1);
        rst = 1'b1;
        #1;
        checks++; if (regs_q !== '0) begin failures++; $display("FAIL midrst_regs got %h exp 0", regs_q); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        got_wq.delete();
        fb[0] = 8'h01; fb[1] = 8'h44;
        do_frame(2);
        checks++; if (regs_q !== mflat()) begin failures++; $display("FAIL midrst_bank got %h exp %h", regs_q, mflat()); end
        checks++; if (regs_q[15:8] !== 8'h44) begin failures++; $display("FAIL midrst_reg1 got %h exp 44", regs_q[15:8]); end
    endtask

    task automatic test_wlock();
        got_wq.delete(); exp_wq.delete();
        fb[0] = 8'h00; fb[1] = 8'h80;
        do_frame(2);
        fb[0] = 8'h01; fb[1] = 8'hAA;
        do_frame(2);
        checks++; if (regs_q !== mflat()) begin failures++; $display("FAIL wlock_bank got %h exp %h", regs_q, mflat()); end
        checks++; if (frame_err !== merr) begin failures++; $display("FAIL wlock_err got %b exp %b", frame_err, merr); end
        checks++; if (got_wq.size() != exp_wq.size()) begin failures++; $display("FAIL wlock_pulses got %0d exp %0d", got_wq.size(), exp_wq.size()); end
        fb[0] = 8'h00; fb[1] = 8'h00;
        do_frame(2);
        fb[0] = 8'h7F; fb[1] = 8'hFF;
        do_frame(2);
    endtask

    task automatic test_random();
        int n, r, a;
        for (int f = 0; f < 40; f++) begin
            got_wq.delete(); exp_wq.delete();
            status_in = 8'($urandom);
            r = $urandom_range(0, 9);
            a = (r < 7) ? $urandom_range(0, N - 1) : (r == 7) ? 127 : $urandom_range(N, 126);
            fb[0] = {1'($urandom_range(0, 1)), 7'(a)};
            n = $urandom_range(1, 6);
            for (int i = 1; i < n; i++) fb[i] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
            do_frame(n);
            for (int i = 0; i < n; i++) begin
                checks++; if (miso[i] !== exp_miso[i]) begin failures++; $display("FAIL rand_miso f%0d b%0d got %h exp %h", f, i, miso[i], exp_miso[i]); end
            end
            checks++; if (regs_q !== mflat()) begin failures++; $display("FAIL rand_bank f%0d got %h exp %h", f, regs_q, mflat()); end
            checks++; if (frame_err !== merr) begin failures++; $display("FAIL rand_err f%0d got %b exp %b", f, frame_err, merr); end
            checks++; if (got_wq.size() != exp_wq.size()) begin failures++; $display("FAIL rand_pulses f%0d got %0d exp %0d", f, got_wq.size(), exp_wq.size()); end
            else for (int i = 0; i < got_wq.size(); i++) begin
                checks++; if (got_wq[i] != exp_wq[i]) begin failures++; $display("FAIL rand_wr_addr f%0d got %0d exp %0d", f, got_wq[i], exp_wq[i]); end
            end
        end
    endtask

    initial begin
        sif.ss = 1'b1; sif.rx_done = 1'b0; sif.rx_byte = 8'h00;
        status_in = 8'h00;
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_status();
        test_abort();
        test_reset_midframe();
        test_wlock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
